// File: rtl/riscv_ctrl_pkg.sv
`timescale 1ns/1ps
// riscv_ctrl_pkg
// Shared definitions for the main decoder and the control pipeline.
// The 8-bit control word is laid out as
//   {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
// and the bit indices below are the single source of truth for that layout.
package riscv_ctrl_pkg;

  localparam int CTRL_W   = 8;

  // Control-word bit positions
  localparam int ALUOP_LO = 0;
  localparam int BRANCH   = 2;
  localparam int MEMWRITE = 3;
  localparam int MEMREAD  = 4;
  localparam int REGWRITE = 5;
  localparam int MEMTOREG = 6;
  localparam int ALUSRC   = 7;

  // A bubble carries no side effects in any later stage
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

  // Opcodes decoded by the main decoder
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_SB = 7'b1100011;

  // Bundle written into the EX-stage register
  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
  } ex_bundle_t;

  function automatic ex_bundle_t ex_bubble();
    ex_bundle_t b;
    b.valid = 1'b0;
    b.ctrl  = CTRL_BUBBLE;
    b.rd    = 5'd0;
    return b;
  endfunction

endpackage

// File: rtl/riscv_hazard_detect.sv
`timescale 1ns/1ps
// riscv_hazard_detect
// Combinational load-use hazard compare between the instruction in EX and
// the instruction in ID.
// Ports:
//   ex_valid, ex_memread, ex_rd     - EX-stage register contents
//   id_valid, id_rs1, id_rs2        - ID-stage instruction sources
//   id_uses_rs2                     - rs2 is a real operand (R/S/SB)
//   hazard                          - ID must wait one cycle for the load
module riscv_hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = (ex_rd == id_rs1);
  // A load's rs2 field is immediate bits, so it only counts when rs2 is read
  assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);

  // x0 is never really written, so a load to x0 cannot create a dependency
  assign hazard = ex_valid && ex_memread && (ex_rd != 5'd0) && id_valid &&
                  (rs1_match || rs2_match);

endmodule

// File: rtl/riscv_ctrl_pipe.sv
`timescale 1ns/1ps
// riscv_ctrl_pipe
// Carries the decoder's control word and rd through the ID->EX->MEM->WB
// pipeline registers, inserts a one-cycle stall plus bubble on a load-use
// hazard, flushes IF/ID on a branch taken in EX, and counts stall cycles and
// taken-branch flushes in saturating counters.
//
// Valid semantics: a stage's *_valid bit qualifies every other field of that
// stage. When valid is 0 the stage is a bubble and its ctrl/rd are forced to
// zero, so nothing downstream can act on it. There is no back-pressure beyond
// the stall: MEM and WB always advance.
//
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   id_valid, id_ctrl, id_rd        - decoded ID instruction (ctrl may be X when !id_valid)
//   id_rs1, id_rs2, id_uses_rs2     - ID source registers for hazard compare
//   ex_zero                         - ALU zero flag for the EX instruction
//   pc_write, ifid_write            - front-end enables, low during a stall
//   ifid_flush, branch_taken        - squash the fetched instruction
//   ex_* / mem_* / wb_*             - stage register contents
//   stall_cnt, flush_cnt            - saturating event counters
module riscv_ctrl_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd,
  input  logic              ex_zero,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              branch_taken,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_rd,
  output logic              mem_valid,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_regwrite,
  output logic              mem_memtoreg,
  output logic [4:0]        mem_rd,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [4:0]        wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic       hazard;
  logic       stall;
  ex_bundle_t ex_next;

  riscv_hazard_detect u_hazard (
    .ex_valid    (ex_valid),
    .ex_memread  (ex_ctrl[MEMREAD]),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (hazard)
  );

  assign branch_taken = ex_valid && ex_ctrl[BRANCH] && ex_zero;
  // A taken branch discards the ID instruction anyway, so it wins over a stall
  assign stall        = hazard && !branch_taken;
  assign pc_write     = !stall;
  assign ifid_write   = !stall;
  assign ifid_flush   = branch_taken;

  // Only a real, non-stalled, non-squashed ID instruction enters EX; every
  // other case loads a clean bubble so X on id_ctrl never propagates.
  always_comb begin
    ex_next = ex_bubble();
    if (id_valid && !stall && !branch_taken) begin
      ex_next.valid = 1'b1;
      ex_next.ctrl  = id_ctrl;
      ex_next.rd    = id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= CTRL_BUBBLE;
      ex_rd        <= 5'd0;
      mem_valid    <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_rd       <= 5'd0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_rd        <= 5'd0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      ex_valid     <= ex_next.valid;
      ex_ctrl      <= ex_next.ctrl;
      ex_rd        <= ex_next.rd;

      mem_valid    <= ex_valid;
      mem_memread  <= ex_ctrl[MEMREAD];
      mem_memwrite <= ex_ctrl[MEMWRITE];
      mem_regwrite <= ex_ctrl[REGWRITE];
      mem_memtoreg <= ex_ctrl[MEMTOREG];
      mem_rd       <= ex_rd;

      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
      wb_rd        <= mem_rd;

      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (branch_taken && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // EX cannot hold both a load and a branch, so these never coincide
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(hazard && branch_taken));
    end
  end

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
`timescale 1ns/1ps
module tb_riscv_ctrl_pipe;

  localparam int SNAP_W = 100;

  // Front-end flags: {pc_write, ifid_write, ifid_flush, branch_taken}
  localparam logic [3:0] F_OK = 4'b1100;
  localparam logic [3:0] F_ST = 4'b0000;
  localparam logic [3:0] F_BR = 4'b1111;
  // EX {valid, ctrl, rd}; MEM {valid, memread, memwrite, regwrite, memtoreg, rd};
  // WB {valid, regwrite, memtoreg, rd}
  localparam logic [13:0] EXB  = 14'd0;
  localparam logic [9:0]  MEMB = 10'd0;
  localparam logic [7:0]  WBB  = 8'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        id_valid = 1'b1;
  logic [7:0]  id_ctrl = 8'h22;
  logic [4:0]  id_rs1 = 5'd0;
  logic [4:0]  id_rs2 = 5'd0;
  logic        id_uses_rs2 = 1'b0;
  logic [4:0]  id_rd = 5'd5;
  logic        ex_zero = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, branch_taken;
  logic        ex_valid;
  logic [7:0]  ex_ctrl;
  logic [4:0]  ex_rd;
  logic        mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
  logic [4:0]  mem_rd;
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_rd;
  logic [31:0] stall_cnt, flush_cnt;

  riscv_ctrl_pipe #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_ctrl      (id_ctrl),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .ex_zero      (ex_zero),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .branch_taken (branch_taken),
    .ex_valid     (ex_valid),
    .ex_ctrl      (ex_ctrl),
    .ex_rd        (ex_rd),
    .mem_valid    (mem_valid),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_regwrite (mem_regwrite),
    .mem_memtoreg (mem_memtoreg),
    .mem_rd       (mem_rd),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_memtoreg  (wb_memtoreg),
    .wb_rd        (wb_rd),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [SNAP_W-1:0] exp_q[$];
  string             name_q[$];
  int                checks = 0;
  int                errors = 0;

  logic [SNAP_W-1:0] act_snap;
  assign act_snap = {pc_write, ifid_write, ifid_flush, branch_taken,
                     ex_valid, ex_ctrl, ex_rd,
                     mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd,
                     wb_valid, wb_regwrite, wb_memtoreg, wb_rd,
                     stall_cnt, flush_cnt};

  // Monitor: one expected snapshot per cycle, sampled mid-cycle on the falling edge
  initial begin
    logic [SNAP_W-1:0] exp_v;
    string             nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        checks++;
        if (act_snap !== exp_v) begin
          errors++;
          $display("FAIL %s: got flags=%b ex=%h mem=%b wb=%b sc=%0d fc=%0d, expected flags=%b ex=%h mem=%b wb=%b sc=%0d fc=%0d",
                   nm, act_snap[99:96], act_snap[95:82], act_snap[81:72], act_snap[71:64],
                   act_snap[63:32], act_snap[31:0],
                   exp_v[99:96], exp_v[95:82], exp_v[81:72], exp_v[71:64],
                   exp_v[63:32], exp_v[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Applies inputs just after a rising edge and queues the outputs expected
  // for the remainder of that cycle.
  task automatic step(input logic r, input logic v, input logic [7:0] c,
                      input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                      input logic [4:0] d, input logic z,
                      input logic [3:0] f, input logic [13:0] ex,
                      input logic [9:0] mem, input logic [7:0] wb,
                      input int sc, input int fc, input string nm);
    logic [31:0] sc_v;
    logic [31:0] fc_v;
    @(posedge clk);
    #1;
    reset = r; id_valid = v; id_ctrl = c; id_rs1 = s1; id_rs2 = s2;
    id_uses_rs2 = u2; id_rd = d; ex_zero = z;
    sc_v = sc;
    fc_v = fc;
    exp_q.push_back({f, ex, mem, wb, sc_v, fc_v});
    name_q.push_back(nm);
  endtask

  initial begin
    // reset held two cycles with a live instruction on the ID inputs
    step(1, 1, 8'h22, 0, 0, 0, 5,  0, F_OK, EXB, MEMB, WBB, 0, 0, "reset_a");
    step(1, 1, 8'h22, 0, 0, 0, 5,  0, F_OK, EXB, MEMB, WBB, 0, 0, "reset_b");
    // add x5 flows EX -> MEM -> WB
    step(0, 1, 8'h22, 1, 2, 1, 5,  0, F_OK, EXB, MEMB, WBB, 0, 0, "add_issue");
    step(0, 0, 8'hFF, 0, 0, 0, 0,  0, F_OK, {1'b1, 8'h22, 5'd5}, MEMB, WBB, 0, 0, "add_ex");
    step(0, 0, 8'hFF, 0, 0, 0, 0,  0, F_OK, EXB, {1'b1, 4'b0010, 5'd5}, WBB, 0, 0, "add_mem");
    step(0, 0, 8'hFF, 0, 0, 0, 0,  0, F_OK, EXB, MEMB, {1'b1, 2'b10, 5'd5}, 0, 0, "add_wb");
    // ld x5 followed by add rs1=x5: one stall cycle
    step(0, 1, 8'hF0, 1, 0, 0, 5,  0, F_OK, EXB, MEMB, WBB, 0, 0, "ld_issue");
    step(0, 1, 8'h22, 5, 2, 1, 6,  0, F_ST, {1'b1, 8'hF0, 5'd5}, MEMB, WBB, 0, 0, "ld_use_stall");
    step(0, 1, 8'h22, 5, 2, 1, 6,  0, F_OK, EXB, {1'b1, 4'b1011, 5'd5}, WBB, 1, 0, "ld_use_release");
    step(0, 0, 8'hFF, 0, 0, 0, 0,  0, F_OK, {1'b1, 8'h22, 5'd6}, MEMB, {1'b1, 2'b11, 5'd5}, 1, 0, "add_after_stall");
    // ld x0 then add rs1=x0: no stall
    step(0, 1, 8'hF0, 1, 0, 0, 0,  0, F_OK, EXB, {1'b1, 4'b0010, 5'd6}, WBB, 1, 0, "ldx0_issue");
    step(0, 1, 8'h22, 0, 0, 1, 7,  0, F_OK, {1'b1, 8'hF0, 5'd0}, MEMB, {1'b1, 2'b10, 5'd6}, 1, 0, "ldx0_no_stall");
    // ld x5 then ld rs1=6 rs2=5 (rs2 unused): no stall
    step(0, 1, 8'hF0, 1, 0, 0, 5,  0, F_OK, {1'b1, 8'h22, 5'd7}, {1'b1, 4'b1011, 5'd0}, WBB, 1, 0, "ld5_issue");
    step(0, 1, 8'hF0, 6, 5, 0, 8,  0, F_OK, {1'b1, 8'hF0, 5'd5}, {1'b1, 4'b0010, 5'd7}, {1'b1, 2'b11, 5'd0}, 1, 0, "ld_rs2_unused");
    // bubble in ID behind a load with matching register fields: no stall
    step(0, 0, 8'hFF, 8, 8, 1, 8,  0, F_OK, {1'b1, 8'hF0, 5'd8}, {1'b1, 4'b1011, 5'd5}, {1'b1, 2'b10, 5'd7}, 1, 0, "bubble_behind_load");
    // ld x9 then sd with rs2=x9: stall through the rs2 path
    step(0, 1, 8'hF0, 1, 0, 0, 9,  0, F_OK, EXB, {1'b1, 4'b1011, 5'd8}, {1'b1, 2'b11, 5'd5}, 1, 0, "ld9_issue");
    step(0, 1, 8'h88, 3, 9, 1, 0,  0, F_ST, {1'b1, 8'hF0, 5'd9}, MEMB, {1'b1, 2'b11, 5'd8}, 1, 0, "rs2_stall");
    step(0, 1, 8'h88, 3, 9, 1, 0,  0, F_OK, EXB, {1'b1, 4'b1011, 5'd9}, WBB, 2, 0, "rs2_release");
    // beq taken: flush, EX bubble despite id_valid
    step(0, 1, 8'h05, 1, 2, 1, 0,  0, F_OK, {1'b1, 8'h88, 5'd0}, MEMB, {1'b1, 2'b11, 5'd9}, 2, 0, "beq_issue");
    step(0, 1, 8'h22, 1, 2, 1, 10, 1, F_BR, {1'b1, 8'h05, 5'd0}, {1'b1, 4'b0100, 5'd0}, WBB, 2, 0, "beq_taken");
    // beq not taken: no flush
    step(0, 1, 8'h05, 1, 2, 1, 0,  1, F_OK, EXB, {1'b1, 4'b0000, 5'd0}, {1'b1, 2'b00, 5'd0}, 2, 1, "beq2_issue");
    step(0, 1, 8'h22, 1, 2, 1, 11, 0, F_OK, {1'b1, 8'h05, 5'd0}, MEMB, {1'b1, 2'b00, 5'd0}, 2, 1, "beq_not_taken");
    // reset asserted in the stall cycle clears everything
    step(0, 1, 8'hF0, 1, 0, 0, 5,  0, F_OK, {1'b1, 8'h22, 5'd11}, {1'b1, 4'b0000, 5'd0}, WBB, 2, 1, "ld_issue2");
    step(1, 1, 8'h22, 5, 2, 1, 6,  0, F_ST, {1'b1, 8'hF0, 5'd5}, {1'b1, 4'b0010, 5'd11}, {1'b1, 2'b00, 5'd0}, 2, 1, "stall_then_reset");
    step(0, 1, 8'h22, 5, 2, 1, 6,  0, F_OK, EXB, MEMB, WBB, 0, 0, "after_reset");
    step(0, 0, 8'hFF, 0, 0, 0, 0,  0, F_OK, {1'b1, 8'h22, 5'd6}, MEMB, WBB, 0, 0, "post_reset_issue");

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
